idex_stage: RTL and testbench
=============================

// Module: idex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard interlock. It captures decoded operands and control from
//  ID and presents them to EX. It also drives the register numbers idex_rs/idex_rt/idex_rd that the
//  forwarding unit compares against the EX/MEM and MEM/WB destinations.
//  It inserts exactly one bubble per load-use hazard, holds on an EX back-pressure stall, and squashes on a
//  branch/jump flush. It counts the bubbles it inserts, for performance reporting.
// PARAMETERS
//  CTRL_W  8   width of the opaque EX/MEM/WB control bundle carried through unchanged
//  CNT_W   16  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1       system clock; single clock domain
//  rst           in   1       synchronous, active-high reset
//  id_valid      in   1       ID slot holds a real instruction
//  id_rs         in   `RegNumPath  source reg A number
//  id_rt         in   `RegNumPath  source reg B number
//  id_rd         in   `RegNumPath  destination reg number (already muxed rt/rd/31 in ID)
//  id_uses_rt    in   1       instruction reads rt as a source (0 for I-type ALU, load)
//  id_rs_data    in   `DataPath    register file read A
//  id_rt_data    in   `DataPath    register file read B
//  id_imm        in   `DataPath    sign/zero-extended immediate
//  id_ctrl       in   CTRL_W  control bundle
//  id_rf_wr_en   in   1       instruction writes the register file
//  id_is_load    in   1       instruction is a memory load
//  flush         in   1       squash the ID/EX slot (taken branch/jump resolved in EX)
//  ex_stall      in   1       EX busy (multi-cycle op); hold ID/EX contents
//  idex_valid    out  1       EX slot holds a real instruction
//  idex_rs/idex_rt/idex_rd    out `RegNumPath  registered register numbers
//  idex_rs_data/idex_rt_data/idex_imm  out `DataPath  registered operands
//  idex_ctrl     out  CTRL_W  registered control
//  idex_rf_wr_en out  1       registered write enable; forced 0 when idex_valid==0
//  idex_is_load  out  1       registered load flag; forced 0 when idex_valid==0
//  pc_stall      out  1       hold the PC this cycle (combinational)
//  ifid_stall    out  1       hold the IF/ID register this cycle (combinational)
//  stall_cnt     out  CNT_W   cumulative bubble cycles inserted, saturating
// BEHAVIOUR
//  - Reset: all idex_* outputs are 0, stall_cnt=0, and state=RUN. pc_stall and ifid_stall are 0 while rst is high.
//  - Hazard: lu_hz = idex_valid & idex_is_load & idex_rd!=0 & id_valid &
//    (idex_rd==id_rs | (id_uses_rt & idex_rd==id_rt)).
//  - Register update per posedge, in priority order:
//    1. rst.
//    2. flush: the slot becomes a bubble.
//    3. ex_stall: hold all registers.
//    4. lu_hz: the slot becomes a bubble.
//    5. Otherwise: capture the id_* inputs.
//  - Bubble means valid=0, rf_wr_en=0, is_load=0, ctrl=0, and reg numbers=0.
//  - Operand data in a bubble is don't-care but must be deterministic; it is cleared to 0.
//  - Squashed instruction: id_valid=0 captures as a bubble (same field rules).
//  - Stall outputs: pc_stall = ifid_stall = ~rst & ~flush & (ex_stall | lu_hz).
//    Flush overrides the stalls, because the fetch stage is redirected.
//  - FSM (2 states):
//    - RUN -> BUBBLE when lu_hz & ~flush & ~ex_stall.
//    - BUBBLE -> RUN unconditionally on the next edge.
//    - In BUBBLE, lu_hz must evaluate 0, because idex_valid=0. The state exists for stall_cnt and for assertion checking.
//  - stall_cnt increments by 1 on each edge where a load-use bubble is inserted and saturates at all-ones.
//    ex_stall cycles and flush cycles are not counted.
//  - Latency: 1 cycle ID->EX. At most one bubble per hazard; the dependent instruction issues on the second cycle.
//  - Simultaneous events:
//    - flush & lu_hz: flush wins and no bubble is counted.
//    - ex_stall & lu_hz: hold. The hazard is re-evaluated after the stall releases.
//  - rst asserted mid-stall clears everything on the next edge and returns to RUN.
//  - Register 0 as the load destination never causes a stall.
// STRUCTURE
//  - Types.v gains:
//    - `CtrlPath
//    - `STALL_CNT_W
//    - state encodings `IDEX_RUN/`IDEX_BUBBLE
//  - Existing `RegNumPath and `DataPath are reused.
//  - One sub-module: load_use_detect, the combinational lu_hz compare. It is kept separate for reuse by a
//    future branch-in-ID hazard check.
//  - Everything else (register, FSM, counter) lives in idex_stage.
// TESTING
//  1. Reset for 2 cycles with id_valid=1 -> all idex_* = 0, stall_cnt=0, pc_stall=0.
//  2. Back-to-back independent ADDs (rd=3, then rs=4, rt=5) -> captured 1 cycle later, no stall, stall_cnt=0.
//  3. LW rd=8, then ADD rs=8 -> one cycle with pc_stall=1 and idex_valid=0. The ADD appears in EX the
//     following cycle. stall_cnt=1.
//  4. LW rd=8, then ADDI rs=9 rt=8 with id_uses_rt=0 -> no stall. LW rd=0, then ADD rs=0 -> no stall.
//  5. LW rd=8, then ADD rs=8 with flush=1 in the same cycle -> bubble, pc_stall=0, stall_cnt unchanged.
//  6. ex_stall=1 for 3 cycles while ADD rd=2 is in EX -> idex_* held and pc_stall=1 throughout. Then:
//     - rst pulse mid-stall -> all cleared, state=RUN.
//     - Preload stall_cnt near all-ones -> saturates.

Source files
------------

// File: rtl/idex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard logic.
// Replaces the legacy Types.v macros (RegNumPath, DataPath, CtrlPath, STALL_CNT_W, IDEX_RUN/BUBBLE).
package idex_stage_pkg;

    localparam int REG_NUM_W   = 5;
    localparam int DATA_W      = 32;
    localparam int CTRL_PATH_W = 8;
    localparam int STALL_CNT_W = 16;

    localparam logic [0:0] IDEX_RUN    = 1'b0;
    localparam logic [0:0] IDEX_BUBBLE = 1'b1;

    typedef logic [REG_NUM_W-1:0] regNum_t;
    typedef logic [DATA_W-1:0]    data_t;

    // Everything in the EX slot except the width-parameterised control bundle.
    typedef struct packed {
        logic    valid;
        regNum_t rs;
        regNum_t rt;
        regNum_t rd;
        data_t   rsData;
        data_t   rtData;
        data_t   imm;
        logic    rfWrEn;
        logic    isLoad;
    } idexSlot_t;

    localparam idexSlot_t BUBBLE_SLOT = '0;

endpackage

// File: rtl/idex_stage_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
// Kept standalone so a branch-in-ID hazard check can reuse it.
module load_use_detect
    import idex_stage_pkg::*;
(
    input  logic    exValid,
    input  logic    exIsLoad,
    input  regNum_t exRd,
    input  logic    idValid,
    input  regNum_t idRs,
    input  regNum_t idRt,
    input  logic    idUsesRt,
    output logic    luHz
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (exRd == idRs);
    assign rtMatch = idUsesRt & (exRd == idRt);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign luHz = exValid & exIsLoad & (exRd != '0) & idValid & (rsMatch | rtMatch);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with a one-bubble load-use interlock, EX back-pressure hold,
// branch/jump flush and a saturating count of inserted bubbles.
module idex_stage
    import idex_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_PATH_W,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  regNum_t           id_rs,
    input  regNum_t           id_rt,
    input  regNum_t           id_rd,
    input  logic              id_uses_rt,
    input  data_t             id_rs_data,
    input  data_t             id_rt_data,
    input  data_t             id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_rf_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              idex_valid,
    output regNum_t           idex_rs,
    output regNum_t           idex_rt,
    output regNum_t           idex_rd,
    output data_t             idex_rs_data,
    output data_t             idex_rt_data,
    output data_t             idex_imm,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_rf_wr_en,
    output logic              idex_is_load,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    idexSlot_t         slot;
    idexSlot_t         idSlot;
    logic [CTRL_W-1:0] ctrlQ;
    logic [CTRL_W-1:0] idCtrl;
    logic [0:0]        state;
    logic [CNT_W-1:0]  stallCnt;
    logic              luHz;
    logic              bubbleIns;

    load_use_detect u_loadUseDetect (
        .exValid  (slot.valid),
        .exIsLoad (slot.isLoad),
        .exRd     (slot.rd),
        .idValid  (id_valid),
        .idRs     (id_rs),
        .idRt     (id_rt),
        .idUsesRt (id_uses_rt),
        .luHz     (luHz)
    );

    // A squashed ID slot is captured as a fully zeroed bubble, operands included.
    assign idSlot = id_valid ? '{valid:  1'b1,
                                 rs:     id_rs,
                                 rt:     id_rt,
                                 rd:     id_rd,
                                 rsData: id_rs_data,
                                 rtData: id_rt_data,
                                 imm:    id_imm,
                                 rfWrEn: id_rf_wr_en,
                                 isLoad: id_is_load}
                             : BUBBLE_SLOT;
    assign idCtrl = id_valid ? id_ctrl : '0;

    assign bubbleIns = luHz & ~flush & ~ex_stall;

    // NOTE: operand data is reset and cleared in bubbles too, so EX never sees stale or X values.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            slot     <= BUBBLE_SLOT;
            ctrlQ    <= '0;
            state    <= IDEX_RUN;
            stallCnt <= '0;
        end else begin
            if (flush) begin
                slot  <= BUBBLE_SLOT;
                ctrlQ <= '0;
            end else if (ex_stall) begin
                slot  <= slot;
                ctrlQ <= ctrlQ;
            end else if (luHz) begin
                slot  <= BUBBLE_SLOT;
                ctrlQ <= '0;
            end else begin
                slot  <= idSlot;
                ctrlQ <= idCtrl;
            end

            case (state)
                IDEX_RUN:    state <= bubbleIns ? IDEX_BUBBLE : IDEX_RUN;
                default:     state <= IDEX_RUN;
            endcase

            if (bubbleIns && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    // Flush redirects fetch, so it must release any hold on PC and IF/ID.
    assign pc_stall   = ~rst & ~flush & (ex_stall | luHz);
    assign ifid_stall = pc_stall;

    assign idex_valid    = slot.valid;
    assign idex_rs       = slot.rs;
    assign idex_rt       = slot.rt;
    assign idex_rd       = slot.rd;
    assign idex_rs_data  = slot.rsData;
    assign idex_rt_data  = slot.rtData;
    assign idex_imm      = slot.imm;
    assign idex_ctrl     = ctrlQ;
    assign idex_rf_wr_en = slot.rfWrEn & slot.valid;
    assign idex_is_load  = slot.isLoad & slot.valid;
    assign stall_cnt     = stallCnt;

    // The bubble cycle always follows its own insertion, so no second hazard can be seen there.
    bubbleStateNoHazard: assert property (@(posedge clk) disable iff (rst)
        (state == IDEX_BUBBLE) |-> (!luHz && !slot.valid));

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: directed hazard scenarios followed by random traffic,
// checked against a transaction-level model of the EX slot.
module tb_idex_stage;

    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit        rst;
        bit        flush;
        bit        exStall;
        bit        valid;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit        usesRt;
        bit [31:0] rsData;
        bit [31:0] rtData;
        bit [31:0] imm;
        bit [7:0]  ctrl;
        bit        wr;
        bit        load;
    } stim_t;

    typedef struct {
        bit        valid;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  rd;
        bit [31:0] rsData;
        bit [31:0] rtData;
        bit [31:0] imm;
        bit [7:0]  ctrl;
        bit        wr;
        bit        load;
    } slot_t;

    typedef struct {
        bit    stall;
        slot_t next;
        int    cnt;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rt;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_rf_wr_en;
    logic              id_is_load;
    logic              flush;
    logic              ex_stall;
    logic              idex_valid;
    logic [4:0]        idex_rs;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    logic [31:0]       idex_rs_data;
    logic [31:0]       idex_rt_data;
    logic [31:0]       idex_imm;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_rf_wr_en;
    logic              idex_is_load;
    logic              pc_stall;
    logic              ifid_stall;
    logic [CNT_W-1:0]  stall_cnt;

    idex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_uses_rt    (id_uses_rt),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .id_rf_wr_en   (id_rf_wr_en),
        .id_is_load    (id_is_load),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .idex_valid    (idex_valid),
        .idex_rs       (idex_rs),
        .idex_rt       (idex_rt),
        .idex_rd       (idex_rd),
        .idex_rs_data  (idex_rs_data),
        .idex_rt_data  (idex_rt_data),
        .idex_imm      (idex_imm),
        .idex_ctrl     (idex_ctrl),
        .idex_rf_wr_en (idex_rf_wr_en),
        .idex_is_load  (idex_is_load),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    slot_t exSlot;
    int    bubbles;
    bit    lastStall;
    bit    driverDone;
    bit    havePrev;
    exp_t  prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t emptySlot();
        slot_t r;
        r = '{default: 0};
        return r;
    endfunction

    // Does the ID instruction actually read register r?
    function automatic bit readsReg(input stim_t s, input bit [4:0] r);
        return (s.rs == r) || (s.usesRt && (s.rt == r));
    endfunction

    function automatic stim_t instr(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                                    input bit [4:0] rd, input bit usesRt, input bit wr,
                                    input bit load);
        stim_t s;
        s = '{default: 0};
        s.valid  = v;
        s.rs     = rs;
        s.rt     = rt;
        s.rd     = rd;
        s.usesRt = usesRt;
        s.wr     = wr;
        s.load   = load;
        s.rsData = $urandom;
        s.rtData = $urandom;
        s.imm    = $urandom;
        s.ctrl   = 8'($urandom_range(1, 255));
        return s;
    endfunction

    // Drive one ID cycle and record what EX must hold after the coming edge.
    task automatic issue(input stim_t s);
        exp_t  e;
        slot_t captured;
        bit    hz;
        @(posedge clk);
        #1;
        rst         = s.rst;
        flush       = s.flush;
        ex_stall    = s.exStall;
        id_valid    = s.valid;
        id_rs       = s.rs;
        id_rt       = s.rt;
        id_rd       = s.rd;
        id_uses_rt  = s.usesRt;
        id_rs_data  = s.rsData;
        id_rt_data  = s.rtData;
        id_imm      = s.imm;
        id_ctrl     = s.ctrl;
        id_rf_wr_en = s.wr;
        id_is_load  = s.load;

        hz = exSlot.valid && exSlot.load && (exSlot.rd != 0) && s.valid && readsReg(s, exSlot.rd);
        e.stall = !s.rst && !s.flush && (s.exStall || hz);

        captured = emptySlot();
        if (s.valid) begin
            captured.valid  = 1'b1;
            captured.rs     = s.rs;
            captured.rt     = s.rt;
            captured.rd     = s.rd;
            captured.rsData = s.rsData;
            captured.rtData = s.rtData;
            captured.imm    = s.imm;
            captured.ctrl   = s.ctrl;
            captured.wr     = s.wr;
            captured.load   = s.load;
        end

        if (s.rst) begin
            exSlot  = emptySlot();
            bubbles = 0;
        end else if (s.flush) begin
            exSlot = emptySlot();
        end else if (s.exStall) begin
            exSlot = exSlot;
        end else if (hz) begin
            exSlot = emptySlot();
            bubbles++;
        end else begin
            exSlot = captured;
        end

        e.next    = exSlot;
        e.cnt     = (bubbles > CNT_MAX) ? CNT_MAX : bubbles;
        lastStall = e.stall;
        q.push_back(e);
    endtask

    task automatic checkRegs(input exp_t e);
        check("idex_valid",    idex_valid,    e.next.valid);
        check("idex_rs",       idex_rs,       e.next.rs);
        check("idex_rt",       idex_rt,       e.next.rt);
        check("idex_rd",       idex_rd,       e.next.rd);
        check("idex_rs_data",  idex_rs_data,  e.next.rsData);
        check("idex_rt_data",  idex_rt_data,  e.next.rtData);
        check("idex_imm",      idex_imm,      e.next.imm);
        check("idex_ctrl",     idex_ctrl,     e.next.ctrl);
        check("idex_rf_wr_en", idex_rf_wr_en, e.next.wr);
        check("idex_is_load",  idex_is_load,  e.next.load);
        check("stall_cnt",     stall_cnt,     e.cnt);
    endtask

    // Monitor: registered outputs answer the previous entry, stall outputs the current one.
    initial begin
        havePrev = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                if (havePrev) checkRegs(prev);
                e = q.pop_front();
                check("pc_stall",   pc_stall,   e.stall);
                check("ifid_stall", ifid_stall, e.stall);
                prev     = e;
                havePrev = 1'b1;
            end else if (havePrev) begin
                checkRegs(prev);
                havePrev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t cur;
        driverDone  = 1'b0;
        exSlot      = emptySlot();
        bubbles     = 0;
        lastStall   = 1'b0;
        rst         = 1'b1;
        flush       = 1'b0;
        ex_stall    = 1'b0;
        id_valid    = 1'b1;
        id_rs       = '0;
        id_rt       = '0;
        id_rd       = '0;
        id_uses_rt  = 1'b0;
        id_rs_data  = '0;
        id_rt_data  = '0;
        id_imm      = '0;
        id_ctrl     = '0;
        id_rf_wr_en = 1'b0;
        id_is_load  = 1'b0;

        // Reset held two cycles with a live instruction presented.
        for (int i = 0; i < 2; i++) begin
            s = instr(1, 1, 2, 3, 1, 1, 0);
            s.rst = 1'b1;
            s.exStall = (i == 1);
            issue(s);
        end

        // Independent back-to-back ADDs.
        issue(instr(1, 1, 2, 3, 1, 1, 0));
        issue(instr(1, 4, 5, 6, 1, 1, 0));

        // LW r8 then dependent ADD: one bubble, ADD held in ID for the bubble cycle.
        issue(instr(1, 1, 0, 8, 0, 1, 1));
        s = instr(1, 8, 9, 10, 1, 1, 0);
        issue(s);
        issue(s);
        issue(instr(0, 0, 0, 0, 0, 0, 0));

        // Non-reading rt and r0 destinations never interlock.
        issue(instr(1, 1, 0, 8, 0, 1, 1));
        issue(instr(1, 9, 8, 11, 0, 1, 0));
        issue(instr(1, 1, 0, 0, 0, 1, 1));
        issue(instr(1, 0, 0, 12, 1, 1, 0));

        // Hazard coinciding with flush: flush wins, nothing counted.
        issue(instr(1, 1, 0, 8, 0, 1, 1));
        s = instr(1, 8, 3, 13, 1, 1, 0);
        s.flush = 1'b1;
        issue(s);
        issue(instr(1, 2, 3, 4, 1, 1, 0));

        // EX back-pressure for 3 cycles behind ADD r2, then reset mid-stall.
        issue(instr(1, 5, 6, 2, 1, 1, 0));
        s = instr(1, 2, 7, 14, 1, 1, 0);
        s.exStall = 1'b1;
        for (int i = 0; i < 3; i++) issue(s);
        s.rst = 1'b1;
        issue(s);
        s.rst = 1'b0;
        s.exStall = 1'b0;
        issue(s);

        // Random traffic over a small register set so load-use hazards are frequent.
        cur = instr(1, 1, 2, 3, 1, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            if (!lastStall) begin
                cur = instr($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 9) < 4);
            end
            cur.rst     = ($urandom_range(0, 99) == 0);
            cur.flush   = ($urandom_range(0, 9) == 0);
            cur.exStall = ($urandom_range(0, 7) == 0);
            issue(cur);
        end

        driverDone = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q.size() + int'(havePrev)), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
